// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and helpers for the matrix-multiplier sharing
//               controller: FSM state encoding, element word width and the
//               flat-matrix width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_C  = 2'd2,
        DELIVER = 2'd3
    } state_t;

    // Bit width of a flat rows x cols matrix of WORD_W elements.
    function automatic int mat_bits(input int rows, input int cols);
        return WORD_W * rows * cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter, purely combinational. The
//               requester named by 'last' (served last) loses a tie.
// Ports       : req[1:0] - request vector
//               last     - index of the requester served last
//               grant    - winning index (valid only when 'valid' is high)
//               valid    - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/matmul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_share_ctrl
// Description : Shares one matrix multiplier between two requesters.
//               Round-robin grant, operand capture, a/b/c strobe-ack
//               sequencing and result return. All outputs are registered.
// Ports       : clk, rst (async, active low)
//               req_stb/req_ack     - per-requester operand handshake
//               req_A0/A1, req_B0/B1- operands per requester
//               res_stb/res_ack     - per-requester result handshake
//               res_C               - shared result bus
//               mm_A, mm_B, mm_a_stb/ack, mm_b_stb/ack - multiplier operands
//               mm_C, mm_c_stb/ack  - multiplier result
//               busy, owner         - status
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_share_ctrl
    import matmul_pkg::*;
#(
    parameter int n = 2,
    parameter int m = 2,
    parameter int p = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_stb,
    output logic [1:0]               req_ack,
    input  logic [mat_bits(n,m)-1:0] req_A0,
    input  logic [mat_bits(n,m)-1:0] req_A1,
    input  logic [mat_bits(m,p)-1:0] req_B0,
    input  logic [mat_bits(m,p)-1:0] req_B1,
    output logic [1:0]               res_stb,
    input  logic [1:0]               res_ack,
    output logic [mat_bits(n,p)-1:0] res_C,
    output logic [mat_bits(n,m)-1:0] mm_A,
    output logic [mat_bits(m,p)-1:0] mm_B,
    output logic                     mm_a_stb,
    output logic                     mm_b_stb,
    input  logic                     mm_a_ack,
    input  logic                     mm_b_ack,
    input  logic [mat_bits(n,p)-1:0] mm_C,
    input  logic                     mm_c_stb,
    output logic                     mm_c_ack,
    output logic                     busy,
    output logic                     owner
);

    localparam int c_WA = mat_bits(n, m);
    localparam int c_WB = mat_bits(m, p);
    localparam int c_WC = mat_bits(n, p);

    state_t            r_state,    w_state_nxt;
    logic              r_ptr,      w_ptr_nxt;
    logic              r_owner,    w_owner_nxt;
    logic [1:0]        r_req_ack,  w_req_ack_nxt;
    logic [c_WA-1:0]   r_mm_A,     w_mm_A_nxt;
    logic [c_WB-1:0]   r_mm_B,     w_mm_B_nxt;
    logic              r_a_stb,    w_a_stb_nxt;
    logic              r_b_stb,    w_b_stb_nxt;
    logic              r_a_done,   w_a_done_nxt;
    logic              r_b_done,   w_b_done_nxt;
    logic              r_c_ack,    w_c_ack_nxt;
    logic [1:0]        r_res_stb,  w_res_stb_nxt;
    logic [c_WC-1:0]   r_res_C,    w_res_C_nxt;
    logic              r_busy,     w_busy_nxt;

    logic              w_gnt;
    logic              w_gnt_valid;

    rr_arb2 u_arb (
        .req   (req_stb),
        .last  (r_ptr),
        .grant (w_gnt),
        .valid (w_gnt_valid)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_req_ack_nxt = 2'b00;
        w_mm_A_nxt    = r_mm_A;
        w_mm_B_nxt    = r_mm_B;
        w_a_stb_nxt   = r_a_stb;
        w_b_stb_nxt   = r_b_stb;
        w_a_done_nxt  = r_a_done;
        w_b_done_nxt  = r_b_done;
        w_c_ack_nxt   = 1'b0;
        w_res_stb_nxt = r_res_stb;
        w_res_C_nxt   = r_res_C;

        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt          = LOAD;
                    w_owner_nxt          = w_gnt;
                    w_req_ack_nxt[w_gnt] = 1'b1;
                    w_mm_A_nxt           = w_gnt ? req_A1 : req_A0;
                    w_mm_B_nxt           = w_gnt ? req_B1 : req_B0;
                    w_a_stb_nxt          = 1'b1;
                    w_b_stb_nxt          = 1'b1;
                    w_a_done_nxt         = 1'b0;
                    w_b_done_nxt         = 1'b0;
                end
            end

            LOAD: begin
                // An ack only counts while its strobe is still offered.
                if (r_a_stb && mm_a_ack) begin
                    w_a_done_nxt = 1'b1;
                    w_a_stb_nxt  = 1'b0;
                end
                if (r_b_stb && mm_b_ack) begin
                    w_b_done_nxt = 1'b1;
                    w_b_stb_nxt  = 1'b0;
                end
                // Leave on the edge that completes the pair so a job with
                // instant acks costs only one cycle here.
                if (w_a_done_nxt && w_b_done_nxt) begin
                    w_a_done_nxt = 1'b0;
                    w_b_done_nxt = 1'b0;
                    w_state_nxt  = WAIT_C;
                end
            end

            WAIT_C: begin
                if (mm_c_stb) begin
                    w_res_C_nxt            = mm_C;
                    w_c_ack_nxt            = 1'b1;
                    w_res_stb_nxt[r_owner] = 1'b1;
                    w_state_nxt            = DELIVER;
                end
            end

            DELIVER: begin
                if (res_ack[r_owner]) begin
                    w_res_stb_nxt = 2'b00;
                    w_ptr_nxt     = r_owner;
                    w_state_nxt   = IDLE;
                end
            end

            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b1;
            r_owner   <= 1'b0;
            r_req_ack <= 2'b00;
            r_mm_A    <= '0;
            r_mm_B    <= '0;
            r_a_stb   <= 1'b0;
            r_b_stb   <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_c_ack   <= 1'b0;
            r_res_stb <= 2'b00;
            r_res_C   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_req_ack <= w_req_ack_nxt;
            r_mm_A    <= w_mm_A_nxt;
            r_mm_B    <= w_mm_B_nxt;
            r_a_stb   <= w_a_stb_nxt;
            r_b_stb   <= w_b_stb_nxt;
            r_a_done  <= w_a_done_nxt;
            r_b_done  <= w_b_done_nxt;
            r_c_ack   <= w_c_ack_nxt;
            r_res_stb <= w_res_stb_nxt;
            r_res_C   <= w_res_C_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign req_ack  = r_req_ack;
    assign res_stb  = r_res_stb;
    assign res_C    = r_res_C;
    assign mm_A     = r_mm_A;
    assign mm_B     = r_mm_B;
    assign mm_a_stb = r_a_stb;
    assign mm_b_stb = r_b_stb;
    assign mm_c_ack = r_c_ack;
    assign busy     = r_busy;
    assign owner    = r_owner;

endmodule
`default_nettype wire
